// File: rtl/mem_pkg.sv
// Shared types for the memory arbiter: request owners and FSM states.
// Owner encoding doubles as the round-robin last-grant pointer (MEM_ARBITER_RR_EN).
package mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_DR   = 2'd2,
    OWN_DW   = 2'd3
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_I  = 2'd1,
    XFER_DR = 2'd2,
    XFER_DW = 2'd3
  } arb_state_t;

  // One-hot grant bit positions.
  localparam int unsigned GNT_I  = 0;
  localparam int unsigned GNT_DR = 1;
  localparam int unsigned GNT_DW = 2;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection; one-hot grant {dw, dr, i}.
// Fixed priority dw > dr > i, or round-robin from the last grant when MEM_ARBITER_RR_EN is defined.
module arb_pick
  import mem_pkg::*;
(
  input  logic       i_ireq,
  input  logic       i_drreq,
  input  logic       i_dwreq,
  input  arb_owner_t i_ptr,
  output logic [2:0] o_gnt
);

`ifdef MEM_ARBITER_RR_EN
  // Search starts at the requester after the last grant: I -> DR -> DW -> I.
  always_comb begin
    o_gnt = 3'b000;
    case (i_ptr)
      OWN_DR: begin
        if (i_dwreq)      o_gnt[GNT_DW] = 1'b1;
        else if (i_ireq)  o_gnt[GNT_I]  = 1'b1;
        else if (i_drreq) o_gnt[GNT_DR] = 1'b1;
      end
      OWN_DW: begin
        if (i_ireq)       o_gnt[GNT_I]  = 1'b1;
        else if (i_drreq) o_gnt[GNT_DR] = 1'b1;
        else if (i_dwreq) o_gnt[GNT_DW] = 1'b1;
      end
      default: begin
        if (i_drreq)      o_gnt[GNT_DR] = 1'b1;
        else if (i_dwreq) o_gnt[GNT_DW] = 1'b1;
        else if (i_ireq)  o_gnt[GNT_I]  = 1'b1;
      end
    endcase
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt = 3'b000;
    if (i_dwreq)      o_gnt[GNT_DW] = 1'b1;
    else if (i_drreq) o_gnt[GNT_DR] = 1'b1;
    else if (i_ireq)  o_gnt[GNT_I]  = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Three-port (fetch, data read, data write) arbiter onto one memory port; one IDLE cycle between transactions.
// Acks are combinational on m_ack; MEM_ARBITER_RR_EN enables round-robin instead of fixed priority.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_ack,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              dr_req,
  input  logic [XLEN-1:0]   dr_addr,
  output logic              dr_ack,
  output logic [XLEN-1:0]   dr_rdata,
  input  logic              dw_req,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_wdata,
  input  logic [XLEN/8-1:0] dw_strb,
  output logic              dw_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_strb,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              busy
);

  arb_state_t        r_state;
  logic              r_m_req;
  logic              r_m_we;
  logic [XLEN-1:0]   r_m_addr;
  logic [XLEN-1:0]   r_m_wdata;
  logic [XLEN/8-1:0] r_m_strb;
  logic [2:0]        w_gnt;
  arb_owner_t        w_ptr;

`ifdef MEM_ARBITER_RR_EN
  arb_owner_t r_ptr;
  assign w_ptr = r_ptr;
`else
  assign w_ptr = OWN_I;
`endif

  arb_pick u_pick (
    .i_ireq  (i_req),
    .i_drreq (dr_req),
    .i_dwreq (dw_req),
    .i_ptr   (w_ptr),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_strb  <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_ptr     <= OWN_I;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt[GNT_DW]) begin
            r_state   <= XFER_DW;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b1;
            r_m_addr  <= dw_addr;
            r_m_wdata <= dw_wdata;
            r_m_strb  <= dw_strb;
`ifdef MEM_ARBITER_RR_EN
            r_ptr     <= OWN_DW;
`endif
          end else if (w_gnt[GNT_DR] || w_gnt[GNT_I]) begin
            r_state   <= w_gnt[GNT_DR] ? XFER_DR : XFER_I;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= w_gnt[GNT_DR] ? dr_addr : i_addr;
            r_m_wdata <= '0;
            r_m_strb  <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_ptr     <= w_gnt[GNT_DR] ? OWN_DR : OWN_I;
`endif
          end
        end
        default: begin
          // Payload stays captured after completion; only m_req drops.
          if (m_ack) begin
            r_state <= IDLE;
            r_m_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_strb  = r_m_strb;
  assign busy    = (r_state != IDLE);

  assign i_ack    = (r_state == XFER_I)  && m_ack;
  assign dr_ack   = (r_state == XFER_DR) && m_ack;
  assign dw_ack   = (r_state == XFER_DW) && m_ack;
  assign i_rdata  = i_ack  ? m_rdata : '0;
  assign dr_rdata = dr_ack ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, collision ordering, fetch, write hold, reset abort, stray ack.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        dr_req;
  logic [31:0] dr_addr;
  logic        dr_ack;
  logic [31:0] dr_rdata;
  logic        dw_req;
  logic [31:0] dw_addr;
  logic [31:0] dw_wdata;
  logic [3:0]  dw_strb;
  logic        dw_ack;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .dr_req   (dr_req),
    .dr_addr  (dr_addr),
    .dr_ack   (dr_ack),
    .dr_rdata (dr_rdata),
    .dw_req   (dw_req),
    .dw_addr  (dw_addr),
    .dw_wdata (dw_wdata),
    .dw_strb  (dw_strb),
    .dw_ack   (dw_ack),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_strb   (m_strb),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  int          ord [3];
  logic [31:0] own_addr [3];
  logic [31:0] rd;

  initial begin
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    dr_req = 1'b0; dr_addr = '0;
    dw_req = 1'b0; dw_addr = '0; dw_wdata = '0; dw_strb = '0;
    m_ack = 1'b0; m_rdata = '0;
    own_addr[0] = 32'h0000_0010;
    own_addr[1] = 32'h0000_0020;
    own_addr[2] = 32'h0000_0030;
`ifdef MEM_ARBITER_RR_EN
    ord[0] = 1; ord[1] = 2; ord[2] = 0;
`else
    ord[0] = 2; ord[1] = 1; ord[2] = 0;
`endif

    // Reset state
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_acks", 32'({dw_ack, dr_ack, i_ack}), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_strb", 32'(m_strb), 32'd0);
    chk("rst_rdata", i_rdata | dr_rdata, 32'd0);
    @(negedge clk);

    // Collision: all three request in the first cycle after reset release
    @(negedge clk);
    reset_n = 1'b1;
    i_req = 1'b1;  i_addr = own_addr[0];
    dr_req = 1'b1; dr_addr = own_addr[1];
    dw_req = 1'b1; dw_addr = own_addr[2]; dw_wdata = 32'hA5A5_0000; dw_strb = 4'hF;
    #1;
    chk1("coll_c0_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd = 32'hC0DE_0000 + 32'(k);
      m_ack = 1'b1; m_rdata = rd;
      #1;
      chk1($sformatf("coll%0d_m_req", k), m_req, 1'b1);
      chk($sformatf("coll%0d_m_addr", k), m_addr, own_addr[ord[k]]);
      chk1($sformatf("coll%0d_m_we", k), m_we, ord[k] == 2);
      chk($sformatf("coll%0d_acks", k), 32'({dw_ack, dr_ack, i_ack}), 32'd1 << ord[k]);
      chk($sformatf("coll%0d_i_rdata", k), i_rdata, (ord[k] == 0) ? rd : 32'd0);
      chk($sformatf("coll%0d_dr_rdata", k), dr_rdata, (ord[k] == 1) ? rd : 32'd0);
      @(negedge clk);
      m_ack = 1'b0;
      case (ord[k])
        0: i_req = 1'b0;
        1: dr_req = 1'b0;
        default: dw_req = 1'b0;
      endcase
      #1;
      chk1($sformatf("coll%0d_idle_m_req", k), m_req, 1'b0);
      chk1($sformatf("coll%0d_idle_busy", k), busy, 1'b0);
      chk($sformatf("coll%0d_idle_acks", k), 32'({dw_ack, dr_ack, i_ack}), 32'd0);
    end

    // Single fetch, m_ack in cycle 2
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0100;
    #1;
    chk1("fetch_c0_m_req", m_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("fetch_c1_m_req", m_req, 1'b1);
    chk("fetch_c1_m_addr", m_addr, 32'h0000_0100);
    chk1("fetch_c1_m_we", m_we, 1'b0);
    chk1("fetch_c1_i_ack", i_ack, 1'b0);
    chk1("fetch_c1_busy", busy, 1'b1);
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("fetch_c2_m_req", m_req, 1'b1);
    chk1("fetch_c2_i_ack", i_ack, 1'b1);
    chk("fetch_c2_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk1("fetch_c2_dr_ack", dr_ack, 1'b0);
    chk("fetch_c2_dr_rdata", dr_rdata, 32'd0);
    @(negedge clk);
    i_req = 1'b0; m_ack = 1'b0;
    #1;
    chk1("fetch_c3_m_req", m_req, 1'b0);
    chk1("fetch_c3_busy", busy, 1'b0);
    chk1("fetch_c3_i_ack", i_ack, 1'b0);

    // Write held over 4 wait cycles, then acked
    @(negedge clk);
    dw_req = 1'b1; dw_addr = 32'h0000_2000; dw_wdata = 32'h1234_5678; dw_strb = 4'h3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk1($sformatf("wr_c%0d_m_req", c), m_req, 1'b1);
      chk1($sformatf("wr_c%0d_m_we", c), m_we, 1'b1);
      chk($sformatf("wr_c%0d_m_addr", c), m_addr, 32'h0000_2000);
      chk($sformatf("wr_c%0d_m_wdata", c), m_wdata, 32'h1234_5678);
      chk($sformatf("wr_c%0d_m_strb", c), 32'(m_strb), 32'h3);
      chk1($sformatf("wr_c%0d_dw_ack", c), dw_ack, 1'b0);
    end
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'h5555_AAAA;
    #1;
    chk1("wr_ack_dw_ack", dw_ack, 1'b1);
    chk1("wr_ack_m_we", m_we, 1'b1);
    chk("wr_ack_rdata", i_rdata | dr_rdata, 32'd0);
    chk("wr_ack_other_acks", 32'({dr_ack, i_ack}), 32'd0);
    @(negedge clk);
    dw_req = 1'b0; m_ack = 1'b0;
    #1;
    chk1("wr_done_dw_ack", dw_ack, 1'b0);
    chk1("wr_done_m_req", m_req, 1'b0);

    // Reset during XFER_DR
    @(negedge clk);
    dr_req = 1'b1; dr_addr = 32'h0000_0044;
    @(negedge clk);
    #1;
    chk1("rdr_c1_m_req", m_req, 1'b1);
    chk("rdr_c1_m_addr", m_addr, 32'h0000_0044);
    @(negedge clk);
    reset_n = 1'b0; m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    #1;
    chk1("rdr_rst_m_req", m_req, 1'b0);
    chk1("rdr_rst_busy", busy, 1'b0);
    chk1("rdr_rst_dr_ack", dr_ack, 1'b0);
    chk("rdr_rst_dr_rdata", dr_rdata, 32'd0);
    chk("rdr_rst_m_addr", m_addr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; dr_req = 1'b0; m_ack = 1'b0;
    #1;
    chk1("rdr_rel_busy", busy, 1'b0);
    @(negedge clk);
    #1;
    chk1("rdr_after_m_req", m_req, 1'b0);
    chk1("rdr_after_dr_ack", dr_ack, 1'b0);

    // Stray m_ack in IDLE
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("stray_acks", 32'({dw_ack, dr_ack, i_ack}), 32'd0);
    chk("stray_rdata", i_rdata | dr_rdata, 32'd0);
    chk1("stray_busy", busy, 1'b0);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    chk1("stray_next_busy", busy, 1'b0);
    chk1("stray_next_m_req", m_req, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
